// File: rtl/cci_mpf_shim_tx_buffer.sv
// MPF TX request buffer: per-channel FIFOs for C0 reads and C1 writes/interrupts with AFU almost-full regeneration.
// Optional direct-to-QLP bypass for empty FIFOs when CCI_MPF_TX_BUFFER_BYPASS_EN is defined.

module cci_mpf_shim_tx_chan #(
   parameter int WIDTH          = 61,
   parameter int DEPTH          = 64,
   parameter int ALM_FULL_SLACK = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pushValid,
   input  logic [WIDTH-1:0]           pushEntry,
   input  logic                       qlpAlmFull,
   output logic                       outValid,
   output logic [WIDTH-1:0]           outEntry,
   output logic                       afuAlmFull,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ALM_THRESH = (AW+1)'(DEPTH - ALM_FULL_SLACK);
   localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr, rdPtr, occNext;
   logic             empty, full, doPop, doPush, doBypass;

   // Pointers carry one extra MSB so equal low bits mean empty or full depending on it.
   assign occupancy = wrPtr - rdPtr;
   assign empty     = (wrPtr == rdPtr);
   assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop     = !empty && !qlpAlmFull;
`ifdef CCI_MPF_TX_BUFFER_BYPASS_EN
   assign doBypass  = pushValid && empty && !qlpAlmFull;
`else
   assign doBypass  = 1'b0;
`endif
   assign doPush    = pushValid && !doBypass && (!full || doPop);

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      occNext = occupancy;
      if (doPush && !doPop)
         occNext = occupancy + PTR_ONE;
      else if (!doPush && doPop)
         occNext = occupancy - PTR_ONE;
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (doPush)
         mem[wrPtr[AW-1:0]] <= pushEntry;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         outValid   <= 1'b0;
         afuAlmFull <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + PTR_ONE;
         if (doPop)
            rdPtr <= rdPtr + PTR_ONE;
         outValid   <= doPop || doBypass;
         afuAlmFull <= (occNext >= ALM_THRESH);
         if (pushValid && full && !doPop)
            overflow <= 1'b1;
      end
   end

   // Payload holds its last value whenever no new request is emitted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (doPop)
            outEntry <= mem[rdPtr[AW-1:0]];
         else if (doBypass)
            outEntry <= pushEntry;
      end
   end
endmodule

module cci_mpf_shim_tx_buffer #(
   parameter int CCI_DATA_WIDTH   = 512,
   parameter int CCI_TX_HDR_WIDTH = 61,
   parameter int DEPTH            = 64,
   parameter int ALM_FULL_SLACK   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CCI_TX_HDR_WIDTH-1:0] afu_C0TxHdr,
   input  logic                        afu_C0TxRdValid,
   output logic                        afu_C0TxAlmFull,
   input  logic [CCI_TX_HDR_WIDTH-1:0] afu_C1TxHdr,
   input  logic [CCI_DATA_WIDTH-1:0]   afu_C1TxData,
   input  logic                        afu_C1TxWrValid,
   input  logic                        afu_C1TxIrValid,
   output logic                        afu_C1TxAlmFull,
   output logic [CCI_TX_HDR_WIDTH-1:0] qlp_C0TxHdr,
   output logic                        qlp_C0TxRdValid,
   input  logic                        qlp_C0TxAlmFull,
   output logic [CCI_TX_HDR_WIDTH-1:0] qlp_C1TxHdr,
   output logic [CCI_DATA_WIDTH-1:0]   qlp_C1TxData,
   output logic                        qlp_C1TxWrValid,
   output logic                        qlp_C1TxIrValid,
   input  logic                        qlp_C1TxAlmFull,
   output logic [$clog2(DEPTH):0]      c0_occupancy,
   output logic [$clog2(DEPTH):0]      c1_occupancy,
   output logic [1:0]                  overflow_err
);
   localparam int C1_WIDTH = 1 + CCI_DATA_WIDTH + CCI_TX_HDR_WIDTH;

   logic                c1IsIntr, c1OutValid, c1OutIsIntr;
   logic [C1_WIDTH-1:0] c1OutEntry;

   cci_mpf_shim_tx_chan #(
      .WIDTH(CCI_TX_HDR_WIDTH), .DEPTH(DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
   ) c0Chan (
      .clk        (clk),
      .reset      (reset),
      .pushValid  (afu_C0TxRdValid),
      .pushEntry  (afu_C0TxHdr),
      .qlpAlmFull (qlp_C0TxAlmFull),
      .outValid   (qlp_C0TxRdValid),
      .outEntry   (qlp_C0TxHdr),
      .afuAlmFull (afu_C0TxAlmFull),
      .occupancy  (c0_occupancy),
      .overflow   (overflow_err[0])
   );

   // A simultaneous write and interrupt keeps the write; the interrupt is dropped.
   assign c1IsIntr = afu_C1TxIrValid && !afu_C1TxWrValid;

   cci_mpf_shim_tx_chan #(
      .WIDTH(C1_WIDTH), .DEPTH(DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
   ) c1Chan (
      .clk        (clk),
      .reset      (reset),
      .pushValid  (afu_C1TxWrValid || afu_C1TxIrValid),
      .pushEntry  ({c1IsIntr, afu_C1TxData, afu_C1TxHdr}),
      .qlpAlmFull (qlp_C1TxAlmFull),
      .outValid   (c1OutValid),
      .outEntry   (c1OutEntry),
      .afuAlmFull (afu_C1TxAlmFull),
      .occupancy  (c1_occupancy),
      .overflow   (overflow_err[1])
   );

   assign {c1OutIsIntr, qlp_C1TxData, qlp_C1TxHdr} = c1OutEntry;
   assign qlp_C1TxWrValid = c1OutValid && !c1OutIsIntr;
   assign qlp_C1TxIrValid = c1OutValid && c1OutIsIntr;

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(afu_C1TxWrValid && afu_C1TxIrValid));
   end
endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Directed bench for cci_mpf_shim_tx_buffer (DEPTH=64, ALM_FULL_SLACK=8); honours CCI_MPF_TX_BUFFER_BYPASS_EN.
`timescale 1ns/1ps

module tb_cci_mpf_shim_tx_buffer;
   localparam int DW = 512;
   localparam int HW = 61;
`ifdef CCI_MPF_TX_BUFFER_BYPASS_EN
   localparam int OFS = 0;
`else
   localparam int OFS = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [HW-1:0] afu_C0TxHdr, afu_C1TxHdr, qlp_C0TxHdr, qlp_C1TxHdr;
   logic [DW-1:0] afu_C1TxData, qlp_C1TxData;
   logic          afu_C0TxRdValid, afu_C0TxAlmFull, afu_C1TxWrValid, afu_C1TxIrValid, afu_C1TxAlmFull;
   logic          qlp_C0TxRdValid, qlp_C0TxAlmFull, qlp_C1TxWrValid, qlp_C1TxIrValid, qlp_C1TxAlmFull;
   logic [6:0]    c0_occupancy, c1_occupancy;
   logic [1:0]    overflow_err;

   int checks = 0;
   int errors = 0;

   cci_mpf_shim_tx_buffer dut (
      .clk(clk), .reset(reset),
      .afu_C0TxHdr(afu_C0TxHdr), .afu_C0TxRdValid(afu_C0TxRdValid), .afu_C0TxAlmFull(afu_C0TxAlmFull),
      .afu_C1TxHdr(afu_C1TxHdr), .afu_C1TxData(afu_C1TxData), .afu_C1TxWrValid(afu_C1TxWrValid),
      .afu_C1TxIrValid(afu_C1TxIrValid), .afu_C1TxAlmFull(afu_C1TxAlmFull),
      .qlp_C0TxHdr(qlp_C0TxHdr), .qlp_C0TxRdValid(qlp_C0TxRdValid), .qlp_C0TxAlmFull(qlp_C0TxAlmFull),
      .qlp_C1TxHdr(qlp_C1TxHdr), .qlp_C1TxData(qlp_C1TxData), .qlp_C1TxWrValid(qlp_C1TxWrValid),
      .qlp_C1TxIrValid(qlp_C1TxIrValid), .qlp_C1TxAlmFull(qlp_C1TxAlmFull),
      .c0_occupancy(c0_occupancy), .c1_occupancy(c1_occupancy), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      afu_C0TxHdr = '0; afu_C0TxRdValid = 1'b0;
      afu_C1TxHdr = '0; afu_C1TxData = '0; afu_C1TxWrValid = 1'b0; afu_C1TxIrValid = 1'b0;
      qlp_C0TxAlmFull = 1'b0; qlp_C1TxAlmFull = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_c0_valid", qlp_C0TxRdValid, 0);
      check("rst_c1_wr", qlp_C1TxWrValid, 0);
      check("rst_c1_ir", qlp_C1TxIrValid, 0);
      check("rst_c0_almfull", afu_C0TxAlmFull, 1);
      check("rst_c1_almfull", afu_C1TxAlmFull, 1);
      check("rst_c0_occ", c0_occupancy, 0);
      check("rst_c1_occ", c1_occupancy, 0);
      check("rst_overflow", overflow_err, 0);
      reset = 1'b0;
      step();
      check("post_rst_c0_almfull", afu_C0TxAlmFull, 0);
      check("post_rst_c1_almfull", afu_C1TxAlmFull, 0);

      // Single read
      afu_C0TxHdr = HW'('h1234); afu_C0TxRdValid = 1'b1;
      step();
      afu_C0TxRdValid = 1'b0;
`ifndef CCI_MPF_TX_BUFFER_BYPASS_EN
      check("single_early_valid", qlp_C0TxRdValid, 0);
      check("single_occ_1", c0_occupancy, 1);
      step();
`endif
      check("single_valid", qlp_C0TxRdValid, 1);
      check("single_hdr", qlp_C0TxHdr, 'h1234);
      check("single_occ_0", c0_occupancy, 0);
      step();
      check("single_valid_drop", qlp_C0TxRdValid, 0);
      check("single_hdr_hold", qlp_C0TxHdr, 'h1234);

      // Fill C1 to the almost-full threshold with the QLP held
      qlp_C1TxAlmFull = 1'b1;
      for (int i = 0; i < 56; i++) begin
         afu_C1TxHdr = HW'(i + 100); afu_C1TxData = DW'(i); afu_C1TxWrValid = 1'b1;
         step();
         if (i == 54) check("fill_almfull_55", afu_C1TxAlmFull, 0);
      end
      afu_C1TxWrValid = 1'b0;
      check("fill_almfull_56", afu_C1TxAlmFull, 1);
      check("fill_occ", c1_occupancy, 56);
      check("fill_no_output", qlp_C1TxWrValid, 0);
      qlp_C1TxAlmFull = 1'b0;
      for (int j = 0; j < 56; j++) begin
         step();
         check("fill_drain_valid", qlp_C1TxWrValid, 1);
         check("fill_drain_data", qlp_C1TxData, DW'(j));
         check("fill_drain_hdr", qlp_C1TxHdr, DW'(j + 100));
      end
      step();
      check("fill_drain_idle", qlp_C1TxWrValid, 0);
      check("fill_drain_occ", c1_occupancy, 0);
      check("fill_drain_almfull", afu_C1TxAlmFull, 0);

      // Overflow C0
      qlp_C0TxAlmFull = 1'b1;
      for (int i = 0; i < 65; i++) begin
         afu_C0TxHdr = HW'(i + 'h200); afu_C0TxRdValid = 1'b1;
         step();
      end
      afu_C0TxRdValid = 1'b0;
      check("ovf_err", overflow_err, 2'b01);
      check("ovf_occ", c0_occupancy, 64);
      qlp_C0TxAlmFull = 1'b0;
      for (int j = 0; j < 64; j++) begin
         step();
         check("ovf_drain_valid", qlp_C0TxRdValid, 1);
         check("ovf_drain_hdr", qlp_C0TxHdr, DW'(j + 'h200));
      end
      step();
      check("ovf_drain_idle", qlp_C0TxRdValid, 0);
      check("ovf_err_sticky", overflow_err, 2'b01);

      // Mixed C1 stream: even index writes, odd index interrupts
      for (int i = 0; i < 10 + OFS; i++) begin
         afu_C1TxWrValid = (i < 10) && (i % 2 == 0);
         afu_C1TxIrValid = (i < 10) && (i % 2 == 1);
         afu_C1TxHdr     = HW'(i + 'h300);
         afu_C1TxData    = DW'(i);
         step();
         if (i >= OFS) begin
            check("mix_wr", qlp_C1TxWrValid, ((i - OFS) % 2 == 0));
            check("mix_ir", qlp_C1TxIrValid, ((i - OFS) % 2 == 1));
            check("mix_hdr", qlp_C1TxHdr, DW'(i - OFS + 'h300));
            if ((i - OFS) % 2 == 0) check("mix_data", qlp_C1TxData, DW'(i - OFS));
         end
      end
      afu_C1TxWrValid = 1'b0; afu_C1TxIrValid = 1'b0;
      step();
      check("mix_idle", qlp_C1TxWrValid | qlp_C1TxIrValid, 0);

      // Reset mid-stream with 20 entries buffered
      qlp_C0TxAlmFull = 1'b1;
      for (int i = 0; i < 20; i++) begin
         afu_C0TxHdr = HW'(i + 'h400); afu_C0TxRdValid = 1'b1;
         step();
      end
      afu_C0TxRdValid = 1'b0;
      check("mid_occ_20", c0_occupancy, 20);
      reset = 1'b1; qlp_C0TxAlmFull = 1'b0;
      step();
      reset = 1'b0;
      check("mid_occ_0", c0_occupancy, 0);
      check("mid_overflow_clr", overflow_err, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("mid_no_valid", qlp_C0TxRdValid, 0);
      end
      check("mid_occ_after", c0_occupancy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cci_mpf_shim_tx_buffer.md
# cci_mpf_shim_tx_buffer

Parametrised TX-request buffering shim for the MPF CCI path. It sits between the AFU-facing side and the QLP-facing side and has two independent FIFOs:
- C0 buffers read requests.
- C1 buffers write and interrupt requests.

It regenerates the AFU-side almost-full flow control from the local FIFO occupancy with a configurable threshold, and drains requests toward the QLP whenever the QLP almost-full is deasserted. RX response signals pass through untouched.

## Interface
- CCI_DATA_WIDTH, 512, C1 write data width
- CCI_TX_HDR_WIDTH, 61, TX header width (C0 and C1)
- DEPTH, 64, entries per FIFO; power of two, ≥4
- ALM_FULL_SLACK, 8, AFU-side almost-full asserts when free entries ≤ this; must be < DEPTH

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- afu_C0TxHdr  in  CCI_TX_HDR_WIDTH  read request header from AFU
- afu_C0TxRdValid  in  1  read request valid
- afu_C0TxAlmFull  out  1  C0 flow control to AFU
- afu_C1TxHdr  in  CCI_TX_HDR_WIDTH  write/interrupt header from AFU
- afu_C1TxData  in  CCI_DATA_WIDTH  write data
- afu_C1TxWrValid  in  1  write valid
- afu_C1TxIrValid  in  1  interrupt valid
- afu_C1TxAlmFull  out  1  C1 flow control to AFU
- qlp_C0TxHdr  out  CCI_TX_HDR_WIDTH  read header to QLP
- qlp_C0TxRdValid  out  1  read valid to QLP
- qlp_C0TxAlmFull  in  1  QLP C0 flow control
- qlp_C1TxHdr  out  CCI_TX_HDR_WIDTH  header to QLP
- qlp_C1TxData  out  CCI_DATA_WIDTH  data to QLP
- qlp_C1TxWrValid  out  1  write valid to QLP
- qlp_C1TxIrValid  out  1  interrupt valid to QLP
- qlp_C1TxAlmFull  in  1  QLP C1 flow control
- c0_occupancy, c1_occupancy  out  $clog2(DEPTH)+1  entries held (debug)
- overflow_err  out  2  sticky per-channel overflow flag, [0]=C0, [1]=C1

## Operation
- C0 FIFO entry: header. C1 FIFO entry: header, data, 1-bit kind (0=write, 1=interrupt).
- Push: any valid from the AFU pushes to that channel's FIFO.
- C1 simultaneous WrValid and IrValid is illegal:
  - the write is pushed and the interrupt is dropped;
  - overflow_err[1] is not set;
  - a simulation assertion fires.
- Pop: a channel pops when its FIFO is non-empty and the qlp_*AlmFull sampled that cycle is 0.
  - A pop loads the QLP-side output register and drives the matching valid for exactly one cycle.
  - Header and data hold their last value when valid is 0.
- Each channel pops at most one entry per cycle. Channels are fully independent.
- Occupancy counter: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- afu_*AlmFull = registered (DEPTH − occupancy_next ≤ ALM_FULL_SLACK).
- Full FIFO with a push and no same-cycle pop:
  - the request is dropped;
  - overflow_err bit sets and stays set until reset;
  - occupancy stays DEPTH.
- Pointers wrap modulo DEPTH. An extra MSB in the counter distinguishes full from empty.
- Reset:
  - pointers and occupancy go to 0;
  - all qlp_* valids go to 0;
  - afu_*AlmFull goes to 1 while reset is high and to 0 the first cycle after;
  - overflow_err goes to 0.
- Reset asserted mid-stream discards all buffered entries. No partial output is emitted.
- RX signals are not in this block; the wrapper connects them straight through.

## Timing
- Push-to-QLP latency with an empty FIFO and QLP not almost-full: 2 cycles. Push at t, FIFO read at t+1, qlp valid at t+2.
- Throughput: 1 request per cycle per channel in steady state.
- QLP almost-full: qlp_*AlmFull high at cycle t means no pop at t and no new valid at t+1. An output already registered at t is still emitted.
- AFU almost-full: afu_*AlmFull reflects occupancy 1 cycle later. ALM_FULL_SLACK must cover the AFU's in-flight reaction window.

## Configuration
- CCI_MPF_TX_BUFFER_BYPASS_EN defined:
  - when a channel's FIFO is empty (and not being popped) and its qlp AlmFull is 0, an incoming request skips the FIFO and is registered directly to the QLP outputs;
  - latency is 1 cycle;
  - occupancy is unaffected;
  - ordering is preserved because bypass only happens when the FIFO is empty.
- Undefined: every request goes through the FIFO with 2-cycle latency.

## Test plan
- Reset release: after reset, both qlp valids = 0, afu AlmFull = 1 during reset and 0 the next cycle, occupancy = 0, overflow_err = 0.
- Single read, C0 header 0x1234, qlp AlmFull = 0: qlp_C0TxRdValid appears at t+2 with the same header (t+1 with BYPASS_EN); occupancy returns to 0.
- Fill: hold qlp_C1TxAlmFull = 1 and push 56 writes with DEPTH=64, SLACK=8. afu_C1TxAlmFull rises the cycle after the 56th push. Releasing the hold drains 56 writes in order, one per cycle.
- Overflow: with qlp held, push 65 C0 reads. The 65th is dropped, overflow_err = 2'b01, occupancy = 64. Drained headers are the first 64 in order.
- Mixed C1: alternate write (data = index) and interrupt for 10 cycles. The output matches the input order, with WrValid/IrValid kinds preserved.
- Reset mid-stream: with 20 entries buffered, pulse reset. No qlp valid appears after reset and occupancy = 0.
